// File: rtl/mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_controller
// Description : Multicycle Moore sequencer for a shared-ALU, single-memory-
//               port MIPS datapath. Decodes the latched op/funct fields and
//               drives every mux select, write strobe and ALU operation.
//               Covers lw, sw, R-type (add, sub, and, or, slt, sll, srl, jr),
//               addi, beq, bne, j and jal. Stalls on mem_ready in FETCH,
//               MEMRD and MEMWR.
// Ports       : clk, reset (sync, active-low)
//               op, funct      - instruction fields from the IR
//               cond           - branch-taken condition from datapath
//               mem_ready      - memory completes current access this cycle
//               pcen, iord, mem_req, memwrite, irwrite, regwrite, regdst,
//               memtoreg, jal, alusrca, alusrcb, alucontrol, pcsrc, beqbne
//                              - datapath controls
//               instr_done     - pulse in the final state of an instruction
//               illegal        - pulse in ILLEGAL
//               state          - current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_controller #(
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       cond,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       jal,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       beqbne,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13,
        S_ILLEGAL = 4'd14
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    // Unknown encodings either trap or fall back to FETCH as a NOP.
    localparam state_t c_BAD_NEXT = STRICT_DECODE ? S_ILLEGAL : S_FETCH;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_funct_valid;
    logic [2:0] w_rtype_alu;

    // ALU operation for the supported R-type functs; w_funct_valid flags them.
    always_comb begin
        w_funct_valid = 1'b1;
        w_rtype_alu   = 3'b010;
        case (funct)
            6'b100000: w_rtype_alu = 3'b010;
            6'b100010: w_rtype_alu = 3'b110;
            6'b100100: w_rtype_alu = 3'b000;
            6'b100101: w_rtype_alu = 3'b001;
            6'b101010: w_rtype_alu = 3'b111;
            6'b000000: w_rtype_alu = 3'b011;
            6'b000010: w_rtype_alu = 3'b100;
            default:   w_funct_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        pcen         = 1'b0;
        iord         = 1'b0;
        mem_req      = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        regwrite     = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        jal          = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        alucontrol   = 3'b000;
        pcsrc        = 2'b00;
        beqbne       = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req      = 1'b1;
                alusrcb      = 2'b01;
                alucontrol   = 3'b010;
                irwrite      = mem_ready;
                pcen         = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
                case (op)
                    c_OP_LW, c_OP_SW:   w_next_state = S_MEMADR;
                    c_OP_RTYPE: begin
                        if (funct == c_FN_JR)   w_next_state = S_JR;
                        else if (w_funct_valid) w_next_state = S_RTYPEEX;
                        else                    w_next_state = c_BAD_NEXT;
                    end
                    c_OP_ADDI:          w_next_state = S_ADDIEX;
                    c_OP_BEQ, c_OP_BNE: w_next_state = S_BRANCH;
                    c_OP_J:             w_next_state = S_JUMP;
                    c_OP_JAL:           w_next_state = S_JAL;
                    default:            w_next_state = c_BAD_NEXT;
                endcase
            end
            S_MEMADR: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                alucontrol   = 3'b010;
                w_next_state = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req      = 1'b1;
                iord         = 1'b1;
                w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req      = 1'b1;
                memwrite     = 1'b1;
                iord         = 1'b1;
                instr_done   = mem_ready;
                w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca      = 1'b1;
                alucontrol   = w_rtype_alu;
                w_next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                beqbne     = op[0];
                pcen       = cond;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                alucontrol   = 3'b010;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4, which becomes the link value.
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                regwrite   = 1'b1;
                jal        = 1'b1;
                instr_done = 1'b1;
            end
            S_JR: begin
                pcsrc      = 2'b11;
                pcen       = 1'b1;
                instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: w_next_state = S_FETCH;
        endcase

        // No side effects may escape while reset is held.
        if (!reset) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            mem_req    = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mc_controller
// Description : Directed bench for mips_mc_controller. A strict-decode
//               instance is checked throughout; a permissive instance shares
//               the same inputs and is checked on the unknown-opcode case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       cond;
    logic       mem_ready;

    logic       pcen, iord, mem_req, memwrite, irwrite, regwrite, regdst;
    logic       memtoreg, jal, alusrca, beqbne, instr_done, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic       n_pcen, n_iord, n_mem_req, n_memwrite, n_irwrite, n_regwrite;
    logic       n_regdst, n_memtoreg, n_jal, n_alusrca, n_beqbne;
    logic       n_instr_done, n_illegal;
    logic [1:0] n_alusrcb, n_pcsrc;
    logic [2:0] n_alucontrol;
    logic [3:0] n_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_mc_controller #(.STRICT_DECODE(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .cond(cond),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .mem_req(mem_req),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .jal(jal), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .beqbne(beqbne), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    mips_mc_controller #(.STRICT_DECODE(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .cond(cond),
        .mem_ready(mem_ready), .pcen(n_pcen), .iord(n_iord),
        .mem_req(n_mem_req), .memwrite(n_memwrite), .irwrite(n_irwrite),
        .regwrite(n_regwrite), .regdst(n_regdst), .memtoreg(n_memtoreg),
        .jal(n_jal), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
        .alucontrol(n_alucontrol), .pcsrc(n_pcsrc), .beqbne(n_beqbne),
        .instr_done(n_instr_done), .illegal(n_illegal), .state(n_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        op        = 6'b000000;
        funct     = 6'b100000;
        cond      = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_state",   state,    4'd0);
        chk("rst_mem_req", mem_req,  1'b0);
        chk("rst_pcen",    pcen,     1'b0);
        chk("rst_irwrite", irwrite,  1'b0);

        // Walk an sw into MEMWR with memory stalled, then reset mid-access.
        reset = 1'b1;
        op    = 6'b101011;
        #1;
        chk("rel_mem_req", mem_req, 1'b1);
        chk("rel_irwrite", irwrite, 1'b1);
        tick();
        chk("sw0_decode", state, 4'd1);
        tick();
        chk("sw0_memadr", state, 4'd2);
        chk("sw0_alusrcb", alusrcb, 2'b10);
        mem_ready = 1'b0;
        tick();
        chk("sw0_memwr", state, 4'd5);
        chk("sw0_memwrite", memwrite, 1'b1);
        reset = 1'b0;
        #1;
        chk("rstmid_memwrite", memwrite, 1'b0);
        chk("rstmid_mem_req",  mem_req,  1'b0);
        tick();
        tick();
        tick();
        chk("rst3_state",    state,    4'd0);
        chk("rst3_memwrite", memwrite, 1'b0);
        chk("rst3_mem_req",  mem_req,  1'b0);
        reset = 1'b1;
        #1;
        chk("rel2_mem_req", mem_req, 1'b1);
        chk("rel2_iord",    iord,    1'b0);

        // lw with memory always ready: states 0..4.
        op        = 6'b100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("lw_state",      state,      i);
            chk("lw_regwrite",   regwrite,   (i == 4));
            chk("lw_memtoreg",   memtoreg,   (i == 4));
            chk("lw_instr_done", instr_done, (i == 4));
            if (i == 3) chk("lw_iord", iord, 1'b1);
            tick();
        end
        chk("lw_back_fetch", state, 4'd0);

        // sw with three stall cycles in MEMWR.
        op = 6'b101011;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sw_state",      state,      4'd5);
            chk("sw_memwrite",   memwrite,   1'b1);
            chk("sw_instr_done", instr_done, 1'b0);
            chk("sw_regwrite",   regwrite,   1'b0);
            if (i < 2) tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_memwrite4", memwrite,   1'b1);
        chk("sw_done4",     instr_done, 1'b1);
        chk("sw_regwrite4", regwrite,   1'b0);
        tick();
        chk("sw_back_fetch", state, 4'd0);

        // beq, not taken.
        op   = 6'b000100;
        cond = 1'b0;
        tick();
        tick();
        chk("beq_state",  state,      4'd8);
        chk("beq_pcen",   pcen,       1'b0);
        chk("beq_beqbne", beqbne,     1'b0);
        chk("beq_alu",    alucontrol, 3'b110);
        chk("beq_pcsrc",  pcsrc,      2'b01);
        chk("beq_done",   instr_done, 1'b1);
        tick();

        // bne, taken.
        op   = 6'b000101;
        cond = 1'b1;
        tick();
        tick();
        chk("bne_state",  state,      4'd8);
        chk("bne_pcen",   pcen,       1'b1);
        chk("bne_beqbne", beqbne,     1'b1);
        chk("bne_alu",    alucontrol, 3'b110);
        chk("bne_pcsrc",  pcsrc,      2'b01);
        cond = 1'b0;
        tick();

        // R-type sub.
        op    = 6'b000000;
        funct = 6'b100010;
        tick();
        tick();
        chk("sub_state",   state,      4'd6);
        chk("sub_alu",     alucontrol, 3'b110);
        chk("sub_alusrca", alusrca,    1'b1);
        chk("sub_alusrcb", alusrcb,    2'b00);
        tick();
        chk("sub_wb_state",    state,      4'd7);
        chk("sub_wb_regwrite", regwrite,   1'b1);
        chk("sub_wb_regdst",   regdst,     1'b1);
        chk("sub_wb_done",     instr_done, 1'b1);
        tick();

        // jr.
        funct = 6'b001000;
        tick();
        tick();
        chk("jr_state", state, 4'd13);
        chk("jr_pcsrc", pcsrc, 2'b11);
        chk("jr_pcen",  pcen,  1'b1);
        tick();

        // jal.
        op = 6'b000011;
        tick();
        tick();
        chk("jal_state",    state,    4'd12);
        chk("jal_jal",      jal,      1'b1);
        chk("jal_regwrite", regwrite, 1'b1);
        chk("jal_pcsrc",    pcsrc,    2'b10);
        tick();

        // addi.
        op = 6'b001000;
        tick();
        tick();
        chk("addi_state",   state,   4'd9);
        chk("addi_alusrcb", alusrcb, 2'b10);
        tick();
        chk("addi_wb_state",    state,    4'd10);
        chk("addi_wb_regwrite", regwrite, 1'b1);
        chk("addi_wb_regdst",   regdst,   1'b0);
        tick();

        // j.
        op = 6'b000010;
        tick();
        tick();
        chk("j_state", state, 4'd11);
        chk("j_pcsrc", pcsrc, 2'b10);
        chk("j_pcen",  pcen,  1'b1);
        tick();
        chk("j_back_fetch", state, 4'd0);

        // Unknown opcode: strict instance traps, permissive one NOPs.
        op = 6'b111111;
        tick();
        chk("ill_decode",      state,   4'd1);
        chk("ill_decode_pcen", pcen,    1'b0);
        chk("ill_decode_flag", illegal, 1'b0);
        tick();
        chk("ill_state",    state,      4'd14);
        chk("ill_flag",     illegal,    1'b1);
        chk("ill_pcen",     pcen,       1'b0);
        chk("ill_regwrite", regwrite,   1'b0);
        chk("ill_memwrite", memwrite,   1'b0);
        chk("ill_done",     instr_done, 1'b0);
        chk("nop_state",    n_state,    4'd0);
        chk("nop_flag",     n_illegal,  1'b0);
        tick();
        chk("ill_back_fetch", state,     4'd0);
        chk("ill_flag_clear", illegal,   1'b0);
        chk("nop_flag2",      n_illegal, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle sequencer for the MIPS core: a Moore FSM that decodes the latched instruction fields and drives every mux select, write strobe and ALU operation of a shared-ALU, single-memory-port datapath. It replaces the single-cycle combinational decoder, lets one memory serve both instruction fetch and data access, and stalls on a memory ready handshake. It covers lw, sw, R-type (add, sub, and, or, slt, sll, srl, jr), addi, beq, bne, j and jal.

## Interface

- STRICT_DECODE, 1: 1 = unknown op/funct enters ILLEGAL (pulses `illegal`); 0 = treated as NOP (DECODE→FETCH, no pulse, no writes)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (asserted when 0, sampled on clk rising edge)
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- cond  in  1  branch-taken condition from datapath (zeroNzero)
- mem_ready  in  1  memory completes current access this cycle
- pcen  out  1  PC register load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_req  out  1  memory access request
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = data register
- jal  out  1  write dest forced to $31, write data = PC
- alusrca  out  1  0 = PC, 1 = A register
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = signimm, 11 = signimm<<2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll, 100 srl
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 00}, 11 = A register
- beqbne  out  1  0 = beq, 1 = bne; equals op[0] in BRANCH, else 0
- instr_done  out  1  one-cycle pulse in final state of each instruction
- illegal  out  1  one-cycle pulse in ILLEGAL
- state  out  4  current state encoding (debug/verification)

## Operation

- States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12, JR 13, ILLEGAL 14. Code 15 unused; unreachable but next state FETCH.
- All outputs are functions of state (plus mem_ready/cond where stated). Any output not listed for a state is 0.
- FETCH: mem_req, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00. irwrite and pcen = mem_ready. Hold until mem_ready, then DECODE.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next by op: 100011/101011→MEMADR; 000000→JR if funct=001000, RTYPEEX if funct is valid, otherwise ILLEGAL; 001000→ADDIEX; 000100/000101→BRANCH; 000010→JUMP; 000011→JAL; otherwise ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10, add. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite, regdst=0, memtoreg=1, instr_done. Next FETCH.
- MEMWR: mem_req, memwrite, iord=1, held together until mem_ready. instr_done = mem_ready. Then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00. Funct decode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, 000000→011, 000010→100. Next RTYPEWB.
- RTYPEWB: regwrite, regdst=1, memtoreg=0, instr_done. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next ADDIWB.
- ADDIWB: regwrite, regdst=0, memtoreg=0, instr_done. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, beqbne=op[0], pcen=cond, instr_done. Next FETCH.
- JUMP: pcsrc=10, pcen, instr_done. Next FETCH.
- JAL: pcsrc=10, pcen, regwrite, jal. PC already holds the return address (jal PC+4). instr_done. Next FETCH.
- JR: pcsrc=11, pcen, instr_done. Next FETCH.
- ILLEGAL: illegal pulse, no writes. Next FETCH.
- Reset: when reset=0 at an edge, the next state is FETCH from any state, including mid-access and while mem_ready is low. During any cycle with reset=0, pcen, irwrite, memwrite, regwrite, mem_req, instr_done and illegal are forced 0.

## Timing

- Reset value: state=0 (FETCH). All strobes 0 while reset is held. The first fetch request is issued in the cycle after reset deasserts.
- Cycle counts with mem_ready constantly 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, jal 3, jr 3, illegal 3 (FETCH, DECODE, ILLEGAL).
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. The controller holds the state and keeps all outputs stable.
- op and funct must be stable from DECODE until the instruction's final state. The IR loads only on the FETCH completion edge.
- Exactly one instr_done pulse per retired instruction; none for illegal instructions.

## Test plan

- Reset: hold reset=0 for 3 cycles from MEMWR with mem_ready=0 → state=0, memwrite=0, mem_req=0; first FETCH with mem_req=1 on the cycle after release.
- lw (op=100011), mem_ready=1 → states 0,1,2,3,4; regwrite=1, memtoreg=1 only in state 4; instr_done once.
- sw, mem_ready low 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles; instr_done on the 4th; regwrite never set.
- beq with cond=0 then bne with cond=1 → pcen=0 / beqbne=0, then pcen=1 / beqbne=1 in state 8; alucontrol=110 and pcsrc=01 both times.
- R-type funct 100010, then jr (funct=001000), then jal (op=000011) → alucontrol=110 with regdst=1 write in state 7; state 13 with pcsrc=11; state 12 with jal=1, regwrite=1, pcsrc=10.
- op=111111 with STRICT_DECODE=1 → states 0,1,14; illegal pulses once; no pcen after FETCH, no regwrite or memwrite; with STRICT_DECODE=0 → states 0,1,0 and illegal stays 0.
